// File: rtl/pwm_mon_pkg.sv
// ============================================================================
// Module : pwm_mon_pkg
// Brief  : Shared types and constants for the PWM duty monitor.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_mon_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      MEAS = 1'b1
   } state_e;

   localparam int CNT_W_DEFAULT = 16;
   localparam int TIMEOUT_MIN   = 2;

   // The period counter must reach TIMEOUT without wrapping.
   function automatic bit timeout_legal(input int timeout, input int cnt_w);
      return (timeout >= TIMEOUT_MIN) &&
             (longint'(timeout) <= ((longint'(1) << cnt_w) - 1));
   endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_edge_sync.sv
// ============================================================================
// Module : pwm_edge_sync
// Brief  : 2-FF synchronizer, optional 3-sample majority filter
//          (PWM_MON_GLITCH_FILTER_EN) and rising-edge detector.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_edge_sync
   import pwm_mon_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic pwm_i,
   output logic s_o,
   output logic rise_o
);

   logic sync1_q;
   logic sync2_q;
   logic s_dly_q;
   logic s_w;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= pwm_i;
         sync2_q <= sync1_q;
      end
   end

`ifdef PWM_MON_GLITCH_FILTER_EN
   // Majority over three consecutive samples: single-cycle pulses and
   // dropouts vanish, longer runs keep their length (delayed by 2 cycles).
   logic [2:0] win_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_q <= 3'b000;
      end else begin
         win_q <= {win_q[1:0], sync2_q};
      end
   end

   assign s_w = (win_q[0] & win_q[1]) | (win_q[0] & win_q[2]) | (win_q[1] & win_q[2]);
`else
   assign s_w = sync2_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_dly_q <= 1'b0;
      end else begin
         s_dly_q <= s_w;
      end
   end

   assign s_o    = s_w;
   assign rise_o = s_w & ~s_dly_q;

endmodule

`default_nettype wire

// File: rtl/pwm_duty_monitor.sv
// ============================================================================
// Module : pwm_duty_monitor
// Brief  : Measures high time and period of each full PWM period and flags
//          stuck-high / stuck-low inputs. Optional glitch filter is enabled
//          by defining PWM_MON_GLITCH_FILTER_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_duty_monitor
   import pwm_mon_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEFAULT,
   parameter int TIMEOUT = 1000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] high_cnt,
   output logic [CNT_W-1:0] period_cnt,
   output logic             meas_valid,
   output logic             stuck_high,
   output logic             stuck_low
);

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

   if (!timeout_legal(TIMEOUT, CNT_W)) begin : g_timeout_illegal
      $error("pwm_duty_monitor: TIMEOUT out of range for CNT_W");
   end

   logic s_w;
   logic rise_w;

   state_e           state_q,      state_d;
   logic [CNT_W-1:0] per_ctr_q,    per_ctr_d;
   logic [CNT_W-1:0] hi_ctr_q,     hi_ctr_d;
   logic [CNT_W-1:0] high_cnt_q,   high_cnt_d;
   logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
   logic             meas_valid_q, meas_valid_d;
   logic             stuck_high_q, stuck_high_d;
   logic             stuck_low_q,  stuck_low_d;

   pwm_edge_sync u_edge_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .pwm_i  (pwm_in),
      .s_o    (s_w),
      .rise_o (rise_w)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         per_ctr_q    <= '0;
         hi_ctr_q     <= '0;
         high_cnt_q   <= '0;
         period_cnt_q <= '0;
         meas_valid_q <= 1'b0;
         stuck_high_q <= 1'b0;
         stuck_low_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         per_ctr_q    <= per_ctr_d;
         hi_ctr_q     <= hi_ctr_d;
         high_cnt_q   <= high_cnt_d;
         period_cnt_q <= period_cnt_d;
         meas_valid_q <= meas_valid_d;
         stuck_high_q <= stuck_high_d;
         stuck_low_q  <= stuck_low_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      per_ctr_d    = per_ctr_q;
      hi_ctr_d     = hi_ctr_q;
      high_cnt_d   = high_cnt_q;
      period_cnt_d = period_cnt_q;
      meas_valid_d = 1'b0;
      stuck_high_d = stuck_high_q;
      stuck_low_d  = stuck_low_q;

      if (!ena) begin
         state_d      = IDLE;
         per_ctr_d    = '0;
         hi_ctr_d     = '0;
         stuck_high_d = 1'b0;
         stuck_low_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               per_ctr_d = '0;
               hi_ctr_d  = '0;
               if (rise_w) begin
                  state_d      = MEAS;
                  per_ctr_d    = ONE_C;
                  hi_ctr_d     = ONE_C;
                  stuck_high_d = 1'b0;
                  stuck_low_d  = 1'b0;
               end
            end
            MEAS: begin
               // A rise on the timeout cycle still completes the period.
               if (rise_w) begin
                  high_cnt_d   = hi_ctr_q;
                  period_cnt_d = per_ctr_q;
                  meas_valid_d = 1'b1;
                  per_ctr_d    = ONE_C;
                  hi_ctr_d     = ONE_C;
                  stuck_high_d = 1'b0;
                  stuck_low_d  = 1'b0;
               end else if (per_ctr_q == TIMEOUT_C) begin
                  state_d      = IDLE;
                  per_ctr_d    = '0;
                  hi_ctr_d     = '0;
                  stuck_high_d = s_w;
                  stuck_low_d  = ~s_w;
               end else begin
                  per_ctr_d = per_ctr_q + ONE_C;
                  hi_ctr_d  = hi_ctr_q + {{(CNT_W-1){1'b0}}, s_w};
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   assign high_cnt   = high_cnt_q;
   assign period_cnt = period_cnt_q;
   assign meas_valid = meas_valid_q;
   assign stuck_high = stuck_high_q;
   assign stuck_low  = stuck_low_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_duty_monitor.sv
// ============================================================================
// Module : tb_pwm_duty_monitor
// Brief  : Scoreboard bench for pwm_duty_monitor (TIMEOUT=20).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_duty_monitor;

   localparam int CNT_W   = 16;
   localparam int TIMEOUT = 20;
`ifdef PWM_MON_GLITCH_FILTER_EN
   localparam int LAT = 5;
`else
   localparam int LAT = 3;
`endif

   localparam int EV_MEAS = 0;
   localparam int EV_SL   = 1;
   localparam int EV_SH   = 2;
   localparam int EV_CLR  = 3;

   typedef struct {
      int kind;
      int a;
      int b;
   } ev_t;

   logic             clk;
   logic             rst_n;
   logic             ena;
   logic             pwm_in;
   logic [CNT_W-1:0] high_cnt;
   logic [CNT_W-1:0] period_cnt;
   logic             meas_valid;
   logic             stuck_high;
   logic             stuck_low;

   ev_t sb_q[$];
   int  tests    = 0;
   int  failures = 0;
   int  cyc      = 0;

   int  prev_valid = 0;
   int  prev_d     = 0;
   int  prev_len   = 0;
   int  flag_set   = 0;
   int  last_rise  = 0;

   logic mon_sl = 1'b0;
   logic mon_sh = 1'b0;
   logic mon_mv = 1'b0;

   pwm_duty_monitor #(
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .pwm_in     (pwm_in),
      .high_cnt   (high_cnt),
      .period_cnt (period_cnt),
      .meas_valid (meas_valid),
      .stuck_high (stuck_high),
      .stuck_low  (stuck_low)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic push(input int kind, input int a, input int b);
      ev_t e;
      e.kind = kind;
      e.a    = a;
      e.b    = b;
      sb_q.push_back(e);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic expect_ev(input string name, input int kind, input int a, input int b);
      ev_t e;
      tests++;
      if (sb_q.size() == 0) begin
         failures++;
         $display("FAIL %s: unexpected event kind=%0d a=%0d b=%0d at cycle %0d, none required",
                  name, kind, a, b, cyc);
      end else begin
         e = sb_q.pop_front();
         if (e.kind != kind || e.a != a || e.b != b) begin
            failures++;
            $display("FAIL %s: got kind=%0d a=%0d b=%0d, required kind=%0d a=%0d b=%0d",
                     name, kind, a, b, e.kind, e.a, e.b);
         end
      end
   endtask

   // Monitor: every observable DUT event is matched against the scoreboard.
   always @(negedge clk) begin
      if (meas_valid) begin
         if (mon_mv) expect_ev("meas_back_to_back", -1, 0, 0);
         expect_ev("meas", EV_MEAS, int'(high_cnt), int'(period_cnt));
      end
      if (stuck_low && !mon_sl)  expect_ev("stuck_low_set", EV_SL, cyc, 0);
      if (stuck_high && !mon_sh) expect_ev("stuck_high_set", EV_SH, cyc, 0);
      if ((mon_sl && !stuck_low) || (mon_sh && !stuck_high))
         expect_ev("stuck_clear", EV_CLR, cyc, 0);
      mon_sl = stuck_low;
      mon_sh = stuck_high;
      mon_mv = meas_valid;
   end

   task automatic drive(input logic v, input int n);
      repeat (n) begin
         pwm_in = v;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic rise_mark();
      int rc;
      rc = cyc + 1;
      if (prev_valid != 0)    push(EV_MEAS, prev_d, prev_len);
      else if (flag_set != 0) push(EV_CLR, rc + LAT - 1, 0);
      flag_set  = 0;
      last_rise = rc;
   endtask

   task automatic period(input int d, input int len);
      rise_mark();
      prev_valid = 1;
      prev_d     = d;
      prev_len   = len;
      drive(1'b1, d);
      drive(1'b0, len - d);
   endtask

   task automatic check_quiet(input string name);
      chk({name, "_high_cnt"},   int'(high_cnt), 0);
      chk({name, "_period_cnt"}, int'(period_cnt), 0);
      chk({name, "_meas_valid"}, int'(meas_valid), 0);
      chk({name, "_stuck_high"}, int'(stuck_high), 0);
      chk({name, "_stuck_low"},  int'(stuck_low), 0);
   endtask

   initial begin
      #100000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached, %0d events pending", sb_q.size());
      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

   initial begin
      rst_n  = 1'b0;
      ena    = 1'b1;
      pwm_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_quiet("reset");
      rst_n = 1'b1;
      drive(1'b0, 3);

      // Duty 5, then stepped 6 and 4 mid-stream.
      repeat (5) period(5, 10);
      repeat (3) period(6, 10);
      repeat (3) period(4, 10);

      // Constant low: stuck_low, then a rise clears it.
      push(EV_SL, last_rise + LAT - 1 + TIMEOUT, 0);
      prev_valid = 0;
      flag_set   = 1;
      drive(1'b0, 30);
      period(5, 10);

      // Constant high: stuck_high, then restart the PWM.
      rise_mark();
      push(EV_SH, last_rise + LAT - 1 + TIMEOUT, 0);
      prev_valid = 0;
      flag_set   = 1;
      drive(1'b1, 40);
      drive(1'b0, 5);
      repeat (3) period(3, 10);

      // Period equal to TIMEOUT: the rise wins over the timeout.
      repeat (2) period(8, TIMEOUT);
      period(5, 10);
`ifndef PWM_MON_GLITCH_FILTER_EN
      period(1, 10);
      period(5, 10);
`endif

      // Reset mid-period.
      rise_mark();
      drive(1'b1, 4);
      drive(1'b0, 2);
      chk("pre_reset_high_cnt", int'(high_cnt), prev_d);
      rst_n      = 1'b0;
      prev_valid = 0;
      flag_set   = 0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check_quiet("mid_reset");
      rst_n = 1'b1;
      drive(1'b0, 3);
      repeat (3) period(5, 10);

      // Enable dropped for 5 cycles mid-period.
      rise_mark();
      drive(1'b1, 6);
      ena = 1'b0;
      drive(1'b0, 5);
      chk("ena_hold_high_cnt",   int'(high_cnt), 5);
      chk("ena_hold_period_cnt", int'(period_cnt), 10);
      chk("ena_stuck_high",      int'(stuck_high), 0);
      chk("ena_stuck_low",       int'(stuck_low), 0);
      ena        = 1'b1;
      prev_valid = 0;
      drive(1'b0, 2);
      repeat (3) period(6, 10);

      // One-cycle glitch inside the low phase.
      period(5, 10);
      rise_mark();
      prev_valid = 1;
      prev_d     = 5;
      prev_len   = 10;
      drive(1'b1, 5);
      drive(1'b0, 2);
`ifndef PWM_MON_GLITCH_FILTER_EN
      prev_len = 7;
      rise_mark();
      prev_d   = 1;
      prev_len = 3;
`endif
      drive(1'b1, 1);
      drive(1'b0, 2);
      repeat (2) period(5, 10);
      drive(1'b0, 8);

      chk("scoreboard_drained", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule

`default_nettype wire
